z80_pad_ctrl: RTL and testbench
===============================

Name: z80_pad_ctrl

Overview:
Parametrised pad-control and bus-interface unit between the ChipIgnite mprj_io pads and a tv80s-based Z80 core.
- Synchronises the asynchronous Z80 input pins.
- Generates a programmable CPU clock-enable.
- Stretches CPU reset.
- Drives the pad output-enable map through an FSM, so address, data and bus-control pins float during reset and bus grant (BUSAK).
- Generalises the fixed 36-pin mapping to arbitrary address and data widths.

Parameters:
ADDR_W, 16, address bus width
DATA_W, 8, data bus width
SYNC_STAGES, 2, flops per input synchroniser (>=2)
DIV_W, 4, width of runtime clock-divide select
RST_HOLD, 4, cpu_cen pulses cpu_reset_n stays low after all reset sources release
PAD_W (localparam), 8+ADDR_W+DATA_W+4, pad count; default 36

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  synchronous, active-high reset
ext_rst_n  in  1  external /RESET pin, asynchronous, active-low
div_sel  in  DIV_W  CPU cen period minus 1
pad_in  in  PAD_W  pad inputs
pad_out  out  PAD_W  pad outputs
pad_oeb  out  PAD_W  0 = drive, 1 = input/float
cpu_cen  out  1  core clock-enable pulse
cpu_reset_n  out  1  stretched core reset
cpu_int_n, cpu_nmi_n, cpu_wait_n, cpu_busrq_n  out  1 each  synchronised inputs
cpu_di  out  DATA_W  data pad inputs, unsynchronised
cpu_a  in  ADDR_W  core address
cpu_dout  in  DATA_W  core write data
cpu_doe  in  1  core write enable
cpu_ctrl_n  in  8  {rfsh,wr,rd,iorq,mreq,m1,busak,halt}, bit 0 = halt

Behaviour:
Pad map:
- [7:0] control outputs, bit order as cpu_ctrl_n.
- [8 +: ADDR_W] address.
- [8+ADDR_W +: DATA_W] data.
- Top four pads, ascending: int, nmi, wait, busrq.
- Input-only pads: pad_oeb=1, pad_out=0 at all times.

Synchronisers:
- Each input pin and ext_rst_n passes through a SYNC_STAGES flop chain.
- Chains reset to 1 (inactive); latency is SYNC_STAGES cycles.

Clock-enable generator:
- Counter cnt counts 0..div_sel_q; cpu_cen=1 in the cycle cnt==div_sel_q, and cnt wraps to 0 there.
- div_sel_q reloads from div_sel only at wrap and at reset, so no short period occurs mid-count.
- div_sel=0 gives cpu_cen constantly 1.
- Reset values: cnt=0, div_sel_q=div_sel, cpu_cen=0.

Reset stretcher:
- Reset source active = wb_rst_i or synchronised ext_rst_n==0.
- While a source is active: hold counter cleared, cpu_reset_n=0.
- After release: counter increments on each cpu_cen; cpu_reset_n goes 1 the cycle after the RST_HOLD-th pulse.
- Any reassertion mid-stretch or mid-run restarts the stretch.

Pad FSM (all pad_out/pad_oeb registered, 1-cycle latency from cpu_* inputs):
- RESET (entered on wb_rst_i or cpu_reset_n==0):
  - Address and data float.
  - Control pads driven to 1 (inactive).
  - Leaves to RUN when cpu_reset_n==1.
- RUN:
  - Address driven with cpu_a; control driven with cpu_ctrl_n.
  - Data pad_oeb = ~cpu_doe, pad_out = cpu_dout.
  - Goes to FLOAT on busak_n==0, sampled only in a cpu_cen cycle.
- FLOAT:
  - Address, data, mreq, iorq, rd, wr: pad_oeb=1, pad_out=0.
  - halt, m1, rfsh, busak stay driven.
  - Goes to TURN on busak_n==1, sampled in a cpu_cen cycle.
- TURN:
  - Exactly one wb_clk_i cycle.
  - mreq/iorq/rd/wr driven to 1; address still floated; data floated.
  - Then goes to RUN.
- Precedence: reset beats everything; from any state, a reset goes to RESET the next cycle.
- Reset values: pad_out=0 except control pads = 1; pad_oeb = 1 except control pads = 0.

Optional Feature:
Z80_PAD_CLKOUT_EN
- Defined: adds output port cpu_clk_o. It toggles on every cpu_cen cycle, giving a 50% external CPU clock at half the cen rate; resets to 0.
- Undefined: port absent, no toggle flop.

Decomposition:
- Package z80_pad_pkg holds:
  - the pad-state enum {RESET, RUN, FLOAT, TURN};
  - control-bit index constants (HALT=0 … RFSH=7);
  - pad-offset functions of ADDR_W/DATA_W.
- One sub-module: z80_pad_sync, a SYNC_STAGES flop chain with parametrised reset value, instantiated 5×.

Test Plan:
- wb_rst_i=1 for 5 cycles then 0, div_sel=0 -> address/data pad_oeb=1 throughout reset; cpu_reset_n rises after exactly 4 cen; address pads drive cpu_a=16'h1234 one cycle later.
- div_sel=3, changed to 1 mid-period -> cpu_cen every 4th cycle until the wrap, then every 2nd; no short pulse.
- pad_in busrq low, core returns busak_n=0 on a cen -> address/data/mreq/iorq/rd/wr pads float next cycle; busak pad drives 0; on busak_n=1: one TURN cycle with rd/wr driven 1, then RUN.
- cpu_doe pulses 1 with cpu_dout=8'hA5 -> data pad_oeb=0 and pad_out=A5 for exactly the pulse length, delayed 1 cycle.
- ext_rst_n glitched low for 3 cycles during RUN -> after SYNC_STAGES cycles cpu_reset_n=0, FSM in RESET; restretched for RST_HOLD cen.
- int pad toggled -> cpu_int_n follows after exactly 2 cycles; input pads always pad_oeb=1, pad_out=0.

Source files
------------

// File: rtl/z80_pad_pkg.sv
// Shared types and pad-map helpers for the Z80 pad controller.
// Pad order: control[7:0], address, data, then int/nmi/wait/busrq.
package z80_pad_pkg;

    typedef enum logic [1:0] {
        RESET,
        RUN,
        FLOAT,
        TURN
    } pad_state_t;

    localparam int HALT  = 0;
    localparam int BUSAK = 1;
    localparam int M1    = 2;
    localparam int MREQ  = 3;
    localparam int IORQ  = 4;
    localparam int RD    = 5;
    localparam int WR    = 6;
    localparam int RFSH  = 7;

    localparam int CTRL_W  = 8;
    localparam int ADDR_LO = 8;

    // Strobes released to the bus master while BUSAK is asserted
    localparam logic [7:0] BUS_MASK = 8'b0111_1000;

    function automatic int data_lo(int aw);
        return 8 + aw;
    endfunction

    function automatic int in_lo(int aw, int dw);
        return 8 + aw + dw;
    endfunction

    function automatic int pad_w(int aw, int dw);
        return 12 + aw + dw;
    endfunction

endpackage

// File: rtl/z80_pad_if.sv
// Core-side bus between the tv80s core and the pad controller.
// master = core, slave = pad controller.
interface z80_pad_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cpu_cen;
    logic              cpu_reset_n;
    logic              cpu_int_n;
    logic              cpu_nmi_n;
    logic              cpu_wait_n;
    logic              cpu_busrq_n;
    logic [DATA_W-1:0] cpu_di;
    logic [ADDR_W-1:0] cpu_a;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_doe;
    logic [7:0]        cpu_ctrl_n;

    modport master (
        input  cpu_cen, cpu_reset_n,
        input  cpu_int_n, cpu_nmi_n,
        input  cpu_wait_n, cpu_busrq_n,
        input  cpu_di,
        output cpu_a, cpu_dout,
        output cpu_doe, cpu_ctrl_n
    );

    modport slave (
        output cpu_cen, cpu_reset_n,
        output cpu_int_n, cpu_nmi_n,
        output cpu_wait_n, cpu_busrq_n,
        output cpu_di,
        input  cpu_a, cpu_dout,
        input  cpu_doe, cpu_ctrl_n
    );

endinterface

// File: rtl/z80_pad_sync.sv
// Multi-flop synchroniser for one asynchronous pin.
// Reset value is a parameter so idle-high pins stay inactive.
module z80_pad_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) chain <= {STAGES{RST_VAL}};
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/z80_pad_ctrl.sv
// Pad control / bus interface between mprj_io and a tv80s Z80 core.
// Define Z80_PAD_CLKOUT_EN to add the cpu_clk_o external clock output.
module z80_pad_ctrl
    import z80_pad_pkg::*;
#(
    parameter  int ADDR_W      = 16,
    parameter  int DATA_W      = 8,
    parameter  int SYNC_STAGES = 2,
    parameter  int DIV_W       = 4,
    parameter  int RST_HOLD    = 4,
    localparam int PAD_W       = pad_w(ADDR_W, DATA_W)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             ext_rst_n,
    input  logic [DIV_W-1:0] div_sel,
    input  logic [PAD_W-1:0] pad_in,
    output logic [PAD_W-1:0] pad_out,
    output logic [PAD_W-1:0] pad_oeb,
`ifdef Z80_PAD_CLKOUT_EN
    output logic             cpu_clk_o,
`endif
    z80_pad_if.slave         cpu
);

    localparam int DL   = data_lo(ADDR_W);
    localparam int IL   = in_lo(ADDR_W, DATA_W);
    localparam int HC_W = $clog2(RST_HOLD + 1);

    logic ext_rst_s;
    logic unused_pads;

    assign unused_pads = ^pad_in[DL-1:0];
    assign cpu.cpu_di  = pad_in[DL +: DATA_W];

    z80_pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_int (
        .clk(wb_clk_i), .rst(wb_rst_i),
        .d(pad_in[IL]), .q(cpu.cpu_int_n)
    );
    z80_pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_nmi (
        .clk(wb_clk_i), .rst(wb_rst_i),
        .d(pad_in[IL+1]), .q(cpu.cpu_nmi_n)
    );
    z80_pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_wait (
        .clk(wb_clk_i), .rst(wb_rst_i),
        .d(pad_in[IL+2]), .q(cpu.cpu_wait_n)
    );
    z80_pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_busrq (
        .clk(wb_clk_i), .rst(wb_rst_i),
        .d(pad_in[IL+3]), .q(cpu.cpu_busrq_n)
    );
    z80_pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ext (
        .clk(wb_clk_i), .rst(wb_rst_i),
        .d(ext_rst_n), .q(ext_rst_s)
    );

    // Divide select is only reloaded at wrap so a period is never cut short
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_sel_q;
    logic             cen;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt       <= '0;
            div_sel_q <= div_sel;
        end else if (cnt == div_sel_q) begin
            cnt       <= '0;
            div_sel_q <= div_sel;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign cen         = ~wb_rst_i & (cnt == div_sel_q);
    assign cpu.cpu_cen = cen;

    logic            rst_src;
    logic [HC_W-1:0] hold;
    logic            reset_n_q;

    assign rst_src = wb_rst_i | ~ext_rst_s;

    always_ff @(posedge wb_clk_i) begin
        if (rst_src) begin
            hold      <= '0;
            reset_n_q <= 1'b0;
        end else if (!reset_n_q && cen) begin
            hold <= hold + HC_W'(1);
            if (hold == HC_W'(RST_HOLD - 1)) reset_n_q <= 1'b1;
        end
    end

    assign cpu.cpu_reset_n = reset_n_q;

    pad_state_t state;
    pad_state_t st_nxt;

    always_comb begin
        st_nxt = state;
        unique case (state)
            RESET: if (reset_n_q) st_nxt = RUN;
            RUN:   if (cen && !cpu.cpu_ctrl_n[BUSAK]) st_nxt = FLOAT;
            FLOAT: if (cen && cpu.cpu_ctrl_n[BUSAK]) st_nxt = TURN;
            TURN:  st_nxt = RUN;
        endcase
        if (wb_rst_i || !reset_n_q) st_nxt = RESET;
    end

    logic [7:0]        ctrl_o, ctrl_e;
    logic [ADDR_W-1:0] addr_o, addr_e;
    logic [DATA_W-1:0] data_o, data_e;

    always_comb begin
        ctrl_o = 8'hFF;
        ctrl_e = 8'h00;
        addr_o = '0;
        addr_e = '1;
        data_o = '0;
        data_e = '1;
        unique case (st_nxt)
            RESET: ;
            RUN: begin
                ctrl_o = cpu.cpu_ctrl_n;
                addr_o = cpu.cpu_a;
                addr_e = '0;
                data_o = cpu.cpu_dout;
                data_e = {DATA_W{~cpu.cpu_doe}};
            end
            FLOAT: begin
                ctrl_o = cpu.cpu_ctrl_n & ~BUS_MASK;
                ctrl_e = BUS_MASK;
            end
            TURN: ctrl_o = cpu.cpu_ctrl_n | BUS_MASK;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= RESET;
            pad_out <= {4'h0, {DATA_W{1'b0}}, {ADDR_W{1'b0}}, 8'hFF};
            pad_oeb <= {4'hF, {DATA_W{1'b1}}, {ADDR_W{1'b1}}, 8'h00};
        end else begin
            state   <= st_nxt;
            pad_out <= {4'h0, data_o, addr_o, ctrl_o};
            pad_oeb <= {4'hF, data_e, addr_e, ctrl_e};
        end
    end

`ifdef Z80_PAD_CLKOUT_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)  cpu_clk_o <= 1'b0;
        else if (cen)  cpu_clk_o <= ~cpu_clk_o;
    end
`endif

endmodule

// File: tb/tb_z80_pad_ctrl.sv
// Directed bench for z80_pad_ctrl: vector table plus reset, divider,
// bus-grant, write-enable, glitch and synchroniser sequences.
module tb_z80_pad_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext_rst_n;
    logic [3:0]  div_sel;
    logic [35:0] pad_in;
    logic [35:0] pad_out;
    logic [35:0] pad_oeb;
`ifdef Z80_PAD_CLKOUT_EN
    logic        clk_o;
`endif

    always #5 clk = ~clk;

    z80_pad_if #(.ADDR_W(16), .DATA_W(8)) cpu ();

    z80_pad_ctrl dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .ext_rst_n (ext_rst_n),
        .div_sel   (div_sel),
        .pad_in    (pad_in),
        .pad_out   (pad_out),
        .pad_oeb   (pad_oeb),
`ifdef Z80_PAD_CLKOUT_EN
        .cpu_clk_o (clk_o),
`endif
        .cpu       (cpu)
    );

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  dout;
        logic        doe;
        logic [7:0]  ctrl;
        logic [35:0] pin;
        logic [35:0] exp_out;
        logic [35:0] exp_oeb;
        logic [7:0]  exp_di;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [35:0] pads(logic [3:0] i, logic [7:0] d,
                                         logic [15:0] a, logic [7:0] c);
        return {i, d, a, c};
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", name, got, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cen();
        int n = 0;
        while (cpu.cpu_cen !== 1'b1 && n < 32) begin
            tick();
            n++;
        end
        chk("cen_wait", 64'(cpu.cpu_cen), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [13:0] cen_bits;
        int          cens;
        int          n;

        vecs[0] = '{16'h1234, 8'hA5, 1'b0, 8'hFF,
                    pads(4'hF, 8'h3C, 16'h0000, 8'h00),
                    pads(4'h0, 8'hA5, 16'h1234, 8'hFF),
                    pads(4'hF, 8'hFF, 16'h0000, 8'h00), 8'h3C};
        vecs[1] = '{16'hABCD, 8'h5A, 1'b1, 8'hFE,
                    pads(4'h0, 8'hC3, 16'hFFFF, 8'hFF),
                    pads(4'h0, 8'h5A, 16'hABCD, 8'hFE),
                    pads(4'hF, 8'h00, 16'h0000, 8'h00), 8'hC3};
        vecs[2] = '{16'h0000, 8'h00, 1'b1, 8'h0A,
                    pads(4'hA, 8'h00, 16'h0000, 8'h00),
                    pads(4'h0, 8'h00, 16'h0000, 8'h0A),
                    pads(4'hF, 8'h00, 16'h0000, 8'h00), 8'h00};
        vecs[3] = '{16'hFFFF, 8'hFF, 1'b0, 8'hF7,
                    pads(4'h5, 8'hFF, 16'h1234, 8'h5A),
                    pads(4'h0, 8'hFF, 16'hFFFF, 8'hF7),
                    pads(4'hF, 8'hFF, 16'h0000, 8'h00), 8'hFF};

        rst            = 1'b1;
        ext_rst_n      = 1'b1;
        div_sel        = 4'd0;
        pad_in         = pads(4'hF, 8'h00, 16'h0000, 8'h00);
        cpu.cpu_a      = 16'h1234;
        cpu.cpu_dout   = 8'h00;
        cpu.cpu_doe    = 1'b0;
        cpu.cpu_ctrl_n = 8'hFF;

        // Reset and stretch
        repeat (5) tick();
        chk("rst_cen", 64'(cpu.cpu_cen), 64'd0);
        chk("rst_reset_n", 64'(cpu.cpu_reset_n), 64'd0);
        chk("rst_out", 64'(pad_out), 64'(pads(4'h0, 8'h00, 16'h0000, 8'hFF)));
        chk("rst_oeb", 64'(pad_oeb), 64'(pads(4'hF, 8'hFF, 16'hFFFF, 8'h00)));
        chk("rst_int", 64'(cpu.cpu_int_n), 64'd1);
        rst = 1'b0;
        tick();
        chk("str_cen1", 64'(cpu.cpu_cen), 64'd1);
        chk("str_rn1", 64'(cpu.cpu_reset_n), 64'd0);
        tick();
        tick();
        chk("str_rn3", 64'(cpu.cpu_reset_n), 64'd0);
        tick();
        chk("str_rn4", 64'(cpu.cpu_reset_n), 64'd1);
        chk("str_oeb4", 64'(pad_oeb), 64'(pads(4'hF, 8'hFF, 16'hFFFF, 8'h00)));
        tick();
        chk("run_out", 64'(pad_out), 64'(pads(4'h0, 8'h00, 16'h1234, 8'hFF)));
        chk("run_oeb", 64'(pad_oeb), 64'(pads(4'hF, 8'hFF, 16'h0000, 8'h00)));

        // Divider change mid-period
        div_sel = 4'd3;
        tick();
        for (int i = 0; i < 14; i++) begin
            cen_bits[i] = cpu.cpu_cen;
            if (i == 5) div_sel = 4'd1;
            tick();
        end
        chk("cen_pattern", 64'(cen_bits), 64'h2A88);

        // Vector table in RUN
        for (int i = 0; i < 4; i++) begin
            cpu.cpu_a      = vecs[i].a;
            cpu.cpu_dout   = vecs[i].dout;
            cpu.cpu_doe    = vecs[i].doe;
            cpu.cpu_ctrl_n = vecs[i].ctrl;
            pad_in         = vecs[i].pin;
            tick();
            chk($sformatf("vec%0d_out", i), 64'(pad_out), 64'(vecs[i].exp_out));
            chk($sformatf("vec%0d_oeb", i), 64'(pad_oeb), 64'(vecs[i].exp_oeb));
            chk($sformatf("vec%0d_di", i), 64'(cpu.cpu_di), 64'(vecs[i].exp_di));
        end
        pad_in         = pads(4'hF, 8'h00, 16'h0000, 8'h00);
        cpu.cpu_a      = 16'h0F0F;
        cpu.cpu_dout   = 8'h00;
        cpu.cpu_doe    = 1'b0;
        cpu.cpu_ctrl_n = 8'hFF;
        repeat (3) tick();

        // Write-enable pulse of 3 cycles
        cpu.cpu_dout = 8'hA5;
        cpu.cpu_doe  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("doe_oeb%0d", i), 64'(pad_oeb),
                64'(pads(4'hF, (i <= 3) ? 8'h00 : 8'hFF, 16'h0000, 8'h00)));
            chk($sformatf("doe_out%0d", i), 64'(pad_out),
                64'(pads(4'h0, 8'hA5, 16'h0F0F, 8'hFF)));
            if (i == 3) cpu.cpu_doe = 1'b0;
        end

        // Bus request / grant / turnaround
        cpu.cpu_dout = 8'h00;
        cpu.cpu_a    = 16'hBEEF;
        pad_in[35]   = 1'b0;
        tick();
        chk("busrq_lat1", 64'(cpu.cpu_busrq_n), 64'd1);
        tick();
        chk("busrq_lat2", 64'(cpu.cpu_busrq_n), 64'd0);
        wait_cen();
        tick();
        chk("busak_nocen", 64'(cpu.cpu_cen), 64'd0);
        cpu.cpu_ctrl_n = 8'hFD;
        tick();
        chk("busak_hold_out", 64'(pad_out), 64'(pads(4'h0, 8'h00, 16'hBEEF, 8'hFD)));
        chk("busak_hold_oeb", 64'(pad_oeb), 64'(pads(4'hF, 8'hFF, 16'h0000, 8'h00)));
        chk("busak_cen", 64'(cpu.cpu_cen), 64'd1);
        tick();
        chk("float_out", 64'(pad_out), 64'(pads(4'h0, 8'h00, 16'h0000, 8'h85)));
        chk("float_oeb", 64'(pad_oeb), 64'(pads(4'hF, 8'hFF, 16'hFFFF, 8'h78)));
        repeat (3) tick();
        chk("float_stay", 64'(pad_oeb), 64'(pads(4'hF, 8'hFF, 16'hFFFF, 8'h78)));
        wait_cen();
        cpu.cpu_ctrl_n = 8'hFF;
        tick();
        chk("turn_out", 64'(pad_out), 64'(pads(4'h0, 8'h00, 16'h0000, 8'hFF)));
        chk("turn_oeb", 64'(pad_oeb), 64'(pads(4'hF, 8'hFF, 16'hFFFF, 8'h00)));
        tick();
        chk("back_out", 64'(pad_out), 64'(pads(4'h0, 8'h00, 16'hBEEF, 8'hFF)));
        chk("back_oeb", 64'(pad_oeb), 64'(pads(4'hF, 8'hFF, 16'h0000, 8'h00)));
        pad_in[35] = 1'b1;
        repeat (3) tick();

        // External reset glitch of 3 cycles during RUN
        ext_rst_n = 1'b0;
        tick();
        chk("glitch_rn1", 64'(cpu.cpu_reset_n), 64'd1);
        tick();
        chk("glitch_rn2", 64'(cpu.cpu_reset_n), 64'd1);
        tick();
        chk("glitch_rn3", 64'(cpu.cpu_reset_n), 64'd0);
        chk("glitch_addr3", 64'(pad_oeb[23:8]), 64'd0);
        ext_rst_n = 1'b1;
        tick();
        chk("glitch_out4", 64'(pad_out), 64'(pads(4'h0, 8'h00, 16'h0000, 8'hFF)));
        chk("glitch_oeb4", 64'(pad_oeb), 64'(pads(4'hF, 8'hFF, 16'hFFFF, 8'h00)));
        tick();
        chk("glitch_rn5", 64'(cpu.cpu_reset_n), 64'd0);
        cens = 0;
        n    = 0;
        while (cpu.cpu_reset_n !== 1'b1 && n < 40) begin
            if (cpu.cpu_cen === 1'b1) cens++;
            tick();
            n++;
        end
        chk("restretch_rn", 64'(cpu.cpu_reset_n), 64'd1);
        chk("restretch_cens", 64'(cens), 64'd4);
        tick();
        chk("restretch_run", 64'(pad_out), 64'(pads(4'h0, 8'h00, 16'hBEEF, 8'hFF)));

        // Interrupt pin synchroniser latency
        pad_in[32] = 1'b0;
        tick();
        chk("int_fall1", 64'(cpu.cpu_int_n), 64'd1);
        tick();
        chk("int_fall2", 64'(cpu.cpu_int_n), 64'd0);
        pad_in[32] = 1'b1;
        tick();
        chk("int_rise1", 64'(cpu.cpu_int_n), 64'd0);
        tick();
        chk("int_rise2", 64'(cpu.cpu_int_n), 64'd1);
        chk("in_pads", 64'({pad_out[35:32], pad_oeb[35:32]}), 64'h0F);

`ifdef Z80_PAD_CLKOUT_EN
        begin
            logic prev;
            wait_cen();
            prev = clk_o;
            tick();
            chk("clk_o_toggle", 64'(clk_o), 64'(~prev));
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
